// File: rtl/i2s_transmitter.sv
// I2S serialiser: shifts stereo PCM frames out on sdata, timed by the sclk/lrclk pair.
// Runs entirely on mclk. A one-frame holding buffer sits between the pipeline and the slots.
module i2s_transmitter #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SLOT_W = 32
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sdata,
  output logic              underrun,
  output logic              frame_err
);

  localparam int unsigned CntW = $clog2(SLOT_W);
  localparam logic [CntW-1:0] CntMax  = CntW'(SLOT_W - 1);
  localparam logic [CntW-1:0] CntData = CntW'(DATA_W);

  logic              sclk_q;
  logic              lr_prev_q, lr_prev_d;
  logic              lr_valid_q, lr_valid_d;
  logic              synced_q, synced_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] act_r_q, act_r_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d;
  logic [DATA_W-1:0] buf_r_q, buf_r_d;
  logic              buf_full_q, buf_full_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;

  logic fall, slot_start, hs;

  assign fall       = sclk_q & ~sclk;
  // lr_valid masks the first fall after reset so a reset taken mid-right-slot
  // is not mistaken for a slot boundary.
  assign slot_start = lr_valid_q & (lrclk != lr_prev_q);
  assign hs         = s_valid & ~buf_full_q;

  assign s_ready   = ~buf_full_q;
  assign sdata     = sdata_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

  always_comb begin
    lr_prev_d   = lr_prev_q;
    lr_valid_d  = lr_valid_q;
    synced_d    = synced_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    act_r_d     = act_r_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    buf_full_d  = buf_full_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (hs) begin
      buf_l_d    = s_left;
      buf_r_d    = s_right;
      buf_full_d = 1'b1;
    end

    if (fall) begin
      lr_prev_d  = lrclk;
      lr_valid_d = 1'b1;
      synced_d   = synced_q | slot_start;

      if (slot_start) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end

      if (slot_start && synced_q && (cnt_q != CntMax)) begin
        frame_err_d = 1'b1;
      end

      if (slot_start && synced_d) begin
        if (!lrclk) begin
          if (buf_full_q) begin
            shreg_d    = buf_l_q;
            act_r_d    = buf_r_q;
            buf_full_d = 1'b0;
          end else begin
            // Empty buffer: send silence; a same-cycle handshake lands for next frame.
            shreg_d    = '0;
            act_r_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          shreg_d = act_r_q;
        end
      end

      if (synced_d && (cnt_d != '0) && (cnt_d <= CntData)) begin
        sdata_d = shreg_q[DATA_W-1];
        shreg_d = shreg_q << 1;
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_valid_q  <= 1'b0;
      synced_q    <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      act_r_q     <= '0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      buf_full_q  <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk;
      lr_prev_q   <= lr_prev_d;
      lr_valid_q  <= lr_valid_d;
      synced_q    <= synced_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      act_r_q     <= act_r_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      buf_full_q  <= buf_full_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
